// File: rtl/imem_loadable_if.sv
// Load, fetch-request and fetch-response bundle of the instruction memory.
// master = the side that loads programs and issues fetches; slave = the memory.
interface imem_loadable_if #(
  parameter int ADDR_W = 6
);
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_pc;
  logic              resp_valid;
  logic [31:0]       resp_instr;
  logic [1:0]        resp_fault;

  modport master (
    output ld_valid, ld_addr, ld_data, req_valid, req_pc,
    input  ld_ready, req_ready, resp_valid, resp_instr, resp_fault
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, req_valid, req_pc,
    output ld_ready, req_ready, resp_valid, resp_instr, resp_fault
  );
endinterface

// File: rtl/imem_loadable.sv
// Loadable instruction memory for the fetch stage.
// After reset it clears itself one word per cycle (DEPTH cycles, busy=1),
// then accepts program loads and fetches every cycle. A fetch accepted at
// edge k is visible on resp_* right after edge k+LATENCY-1, i.e. a consumer
// samples it LATENCY edges after the accept. Misaligned / out-of-range PCs
// return a NOP (0) with fault bits instead of aliasing.
// Optional macro IMEM_BOOT_PROG_EN: the clear pass writes a 3-word boot
// program at words 0..2 instead of zeros.
module imem_loadable #(
  parameter  int DEPTH   = 64,
  parameter  int LATENCY = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  imem_loadable_if.slave   bus,
  output logic             busy
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [31:0]       mem [DEPTH];
  logic              ld_fire, req_fire;
  logic [ADDR_W-1:0] rd_idx;
  logic [1:0]        fault_in;
  logic [31:0]       clr_word;

  logic [LATENCY:1]        vld_pipe;
  logic [LATENCY:1][31:0]  instr_pipe;
  logic [LATENCY:1][1:0]   fault_pipe;

  assign ld_fire  = bus.ld_valid  & bus.ld_ready;
  assign req_fire = bus.req_valid & bus.req_ready;
  assign rd_idx   = bus.req_pc[ADDR_W+1:2];
  // Any set bit above the word index means the PC is past the array.
  assign fault_in = {|bus.req_pc[31:ADDR_W+2], |bus.req_pc[1:0]};

  // Word written by the clear pass at the current counter position.
  always_comb begin
    clr_word = '0;
`ifdef IMEM_BOOT_PROG_EN
    case (cnt)
      ADDR_W'(0): clr_word = 32'h2010_0015;  // addi $16,$0,21
      ADDR_W'(1): clr_word = 32'h2011_0017;  // addi $17,$0,23
      ADDR_W'(2): clr_word = 32'h0800_0000;  // j 0
      default:    clr_word = '0;
    endcase
`endif
  end

  // State register and clear counter; the counter wraps back to 0 on exit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  // Next state and handshake readiness.
  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    bus.ld_ready  = 1'b0;
    bus.req_ready = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (cnt == ADDR_W'(DEPTH-1)) state_nxt = RUN;
      end
      RUN: begin
        bus.ld_ready  = 1'b1;
        bus.req_ready = 1'b1;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Single write port: clear pass while clearing, program loads while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == CLEAR)  mem[cnt]         <= clr_word;
      else if (ld_fire)    mem[bus.ld_addr] <= bus.ld_data;
    end
  end

  // Response pipeline. Stage 1 reads the array at the accept edge, so a
  // same-edge load to that word is not yet visible (read-before-write).
  // Data stages only move with a valid, so outputs hold between pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe   <= '0;
      instr_pipe <= '0;
      fault_pipe <= '0;
    end else begin
      vld_pipe[1] <= req_fire;
      if (req_fire) begin
        instr_pipe[1] <= (|fault_in) ? 32'h0 : mem[rd_idx];
        fault_pipe[1] <= fault_in;
      end
      for (int i = 2; i <= LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) begin
          instr_pipe[i] <= instr_pipe[i-1];
          fault_pipe[i] <= fault_pipe[i-1];
        end
      end
    end
  end

  assign bus.resp_valid = vld_pipe[LATENCY];
  assign bus.resp_instr = instr_pipe[LATENCY];
  assign bus.resp_fault = fault_pipe[LATENCY];

endmodule
